// File: rtl/conv3x3_stream_filter_pkg.sv
// Shared types and arithmetic helpers for the 3x3 streaming filter.
// Kernel taps are split into "side" rows (top/bottom) and the middle row, each with edge and centre taps.
package conv3x3_pkg;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_GAUSS = 2'd1,
        MODE_SHARP = 2'd2
    } mode_e;

    localparam int K_PASS_EDGE       = 32'sd0;
    localparam int K_PASS_SIDE_CTR   = 32'sd0;
    localparam int K_PASS_MID_CTR    = 32'sd1;
    localparam int K_GAUSS_SIDE_EDGE = 32'sd1;
    localparam int K_GAUSS_SIDE_CTR  = 32'sd2;
    localparam int K_GAUSS_MID_EDGE  = 32'sd2;
    localparam int K_GAUSS_MID_CTR   = 32'sd4;
    localparam int K_SHARP_SIDE_EDGE = 32'sd0;
    localparam int K_SHARP_SIDE_CTR  = -32'sd1;
    localparam int K_SHARP_MID_EDGE  = -32'sd1;
    localparam int K_SHARP_MID_CTR   = 32'sd5;
    localparam int GAUSS_SHIFT       = 32'sd4;

    function automatic int sum_w(input int dw);
        return dw + 32'sd5;
    endfunction

    function automatic int clamp_px(input int v, input int dw);
        int max_v;
        max_v = (32'sd1 <<< dw) - 32'sd1;
        if (v < 32'sd0) begin
            return 32'sd0;
        end else if (v > max_v) begin
            return max_v;
        end else begin
            return v;
        end
    endfunction

    // encoding 3 is an alias for the Gaussian kernel
    function automatic mode_e decode_mode(input logic [1:0] m);
        case (m)
            2'd0:    return MODE_PASS;
            2'd2:    return MODE_SHARP;
            default: return MODE_GAUSS;
        endcase
    endfunction

endpackage

// File: rtl/conv3x3_stream_filter_row_mac.sv
// One kernel row: 3-tap weighted sum of left/centre/right pixels, taps chosen by mode and row position.
module conv3x3_row_mac
    import conv3x3_pkg::*;
#(
    parameter int DW      = 8,
    parameter bit MID_ROW = 1'b0
) (
    input  mode_e                        mode,
    input  logic [DW-1:0]                px_l,
    input  logic [DW-1:0]                px_c,
    input  logic [DW-1:0]                px_r,
    output logic signed [sum_w(DW)-1:0]  sum
);

    localparam int SUM_W = sum_w(DW);

    logic signed [SUM_W-1:0] k_edge_s;
    logic signed [SUM_W-1:0] k_ctr_s;
    logic signed [SUM_W-1:0] l_s;
    logic signed [SUM_W-1:0] c_s;
    logic signed [SUM_W-1:0] r_s;

    assign l_s = $signed({{(SUM_W-DW){1'b0}}, px_l});
    assign c_s = $signed({{(SUM_W-DW){1'b0}}, px_c});
    assign r_s = $signed({{(SUM_W-DW){1'b0}}, px_r});

    // tap selection for this row
    always_comb begin
        k_edge_s = {SUM_W{1'b0}};
        k_ctr_s  = {SUM_W{1'b0}};
        case (mode)
            MODE_PASS: begin
                k_edge_s = SUM_W'(K_PASS_EDGE);
                k_ctr_s  = SUM_W'(MID_ROW ? K_PASS_MID_CTR : K_PASS_SIDE_CTR);
            end
            MODE_SHARP: begin
                k_edge_s = SUM_W'(MID_ROW ? K_SHARP_MID_EDGE : K_SHARP_SIDE_EDGE);
                k_ctr_s  = SUM_W'(MID_ROW ? K_SHARP_MID_CTR : K_SHARP_SIDE_CTR);
            end
            default: begin
                k_edge_s = SUM_W'(MID_ROW ? K_GAUSS_MID_EDGE : K_GAUSS_SIDE_EDGE);
                k_ctr_s  = SUM_W'(MID_ROW ? K_GAUSS_MID_CTR : K_GAUSS_SIDE_CTR);
            end
        endcase
    end

    assign sum = k_edge_s * l_s + k_ctr_s * c_s + k_edge_s * r_s;

endmodule

// File: rtl/conv3x3_stream_filter.sv
// Streaming 3x3 filter: column window, three-stage tagged pipeline (row sums, total, normalise/clamp),
// per-line done pulse and output count.
module conv3x3_stream_filter
    import conv3x3_pkg::*;
#(
    parameter int DW    = 8,
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [1:0]       mode_i,
    input  logic             valid_i,
    input  logic             sol_i,
    input  logic             eol_i,
    input  logic [DW-1:0]    d1_i,
    input  logic [DW-1:0]    d2_i,
    input  logic [DW-1:0]    d3_i,
    output logic             valid_o,
    output logic [DW-1:0]    pix_o,
    output logic             eol_o,
    output logic             done_o,
    output logic [CNT_W-1:0] out_cnt_o
);

    localparam int SUM_W = sum_w(DW);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic                    beat_s;
    logic                    full_s;
    logic [2:0][DW-1:0]      d_s;
    logic [2:0][DW-1:0]      c0_r;
    logic [2:0][DW-1:0]      c1_r;
    logic [1:0]              col_cnt_r;
    logic [1:0]              col_cnt_nxt_s;
    mode_e                   line_mode_r;
    mode_e                   line_mode_nxt_s;
    logic [CNT_W-1:0]        line_cnt_r;
    logic [CNT_W-1:0]        base_cnt_s;
    logic [CNT_W-1:0]        line_cnt_nxt_s;
    logic signed [SUM_W-1:0] row_sum_s [3];
    logic signed [SUM_W-1:0] s1_row_r [3];
    logic                    s1_valid_r, s1_eol_r, s2_valid_r, s2_eol_r;
    mode_e                   s1_mode_r, s2_mode_r;
    logic [CNT_W-1:0]        s1_cnt_r, s2_cnt_r;
    logic signed [SUM_W-1:0] s2_total_r;
    logic signed [SUM_W-1:0] norm_s;
    logic [DW-1:0]           pix_s;

    assign beat_s = en_i & valid_i;
    assign d_s    = {d3_i, d2_i, d1_i};

    // line state as it stands after the current beat
    always_comb begin
        col_cnt_nxt_s   = col_cnt_r;
        line_mode_nxt_s = line_mode_r;
        base_cnt_s      = line_cnt_r;
        if (sol_i) begin
            col_cnt_nxt_s   = 2'd1;
            line_mode_nxt_s = decode_mode(mode_i);
            base_cnt_s      = {CNT_W{1'b0}};
        end else begin
            col_cnt_nxt_s = (col_cnt_r == 2'd3) ? 2'd3 : col_cnt_r + 2'd1;
        end
        full_s = (col_cnt_nxt_s == 2'd3);
        if (full_s && (base_cnt_s != CNT_MAX)) begin
            line_cnt_nxt_s = base_cnt_s + CNT_W'(1);
        end else begin
            line_cnt_nxt_s = base_cnt_s;
        end
    end

    // S1 works on the post-shift window (c1 -> left, c0 -> centre, input -> right), so an oldest column is never stored
    genvar r;
    generate
        for (r = 0; r < 3; r++) begin : g_row
            conv3x3_row_mac #(.DW(DW), .MID_ROW(r == 1)) u_row_mac (
                .mode (line_mode_nxt_s),
                .px_l (c1_r[r]),
                .px_c (c0_r[r]),
                .px_r (d_s[r]),
                .sum  (row_sum_s[r])
            );
        end
    endgenerate

    // window columns and per-line state advance only on accepted beats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c0_r        <= {(3*DW){1'b0}};
            c1_r        <= {(3*DW){1'b0}};
            col_cnt_r   <= 2'd0;
            line_mode_r <= MODE_PASS;
            line_cnt_r  <= {CNT_W{1'b0}};
        end else if (beat_s) begin
            c1_r        <= c0_r;
            c0_r        <= d_s;
            col_cnt_r   <= col_cnt_nxt_s;
            line_mode_r <= line_mode_nxt_s;
            line_cnt_r  <= line_cnt_nxt_s;
        end
    end

    // S1/S2: tags, launch mode and line count travel with the data every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                s1_row_r[i] <= {SUM_W{1'b0}};
            end
            s1_valid_r <= 1'b0;
            s1_eol_r   <= 1'b0;
            s1_mode_r  <= MODE_PASS;
            s1_cnt_r   <= {CNT_W{1'b0}};
            s2_total_r <= {SUM_W{1'b0}};
            s2_valid_r <= 1'b0;
            s2_eol_r   <= 1'b0;
            s2_mode_r  <= MODE_PASS;
            s2_cnt_r   <= {CNT_W{1'b0}};
        end else begin
            for (int i = 0; i < 3; i++) begin
                s1_row_r[i] <= row_sum_s[i];
            end
            s1_valid_r <= beat_s & full_s;
            s1_eol_r   <= beat_s & eol_i;
            s1_mode_r  <= line_mode_nxt_s;
            s1_cnt_r   <= line_cnt_nxt_s;
            s2_total_r <= s1_row_r[0] + s1_row_r[1] + s1_row_r[2];
            s2_valid_r <= s1_valid_r;
            s2_eol_r   <= s1_eol_r;
            s2_mode_r  <= s1_mode_r;
            s2_cnt_r   <= s1_cnt_r;
        end
    end

    // Gaussian total is scaled by its kernel weight; every mode then clamps into pixel range
    always_comb begin
        norm_s = s2_total_r;
        case (s2_mode_r)
            MODE_PASS:  norm_s = s2_total_r;
            MODE_SHARP: norm_s = s2_total_r;
            default:    norm_s = s2_total_r >>> GAUSS_SHIFT;
        endcase
        pix_s = DW'(clamp_px(int'(norm_s), DW));
    end

    // S3: registered outputs; pix_o and out_cnt_o hold between updates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_o   <= 1'b0;
            pix_o     <= {DW{1'b0}};
            eol_o     <= 1'b0;
            done_o    <= 1'b0;
            out_cnt_o <= {CNT_W{1'b0}};
        end else begin
            valid_o <= s2_valid_r;
            eol_o   <= s2_valid_r & s2_eol_r;
            done_o  <= s2_eol_r;
            if (s2_valid_r) begin
                pix_o <= pix_s;
            end
            if (s2_eol_r) begin
                out_cnt_o <= s2_cnt_r;
            end
        end
    end

endmodule
